uart_reporter: RTL and testbench



---
 rtl/uart_reporter.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_reporter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reporter.sv
// -----------------------------------------------------------------------------
// uart_reporter
//
// Formats game events into ASCII messages and streams them one byte at a time
// into the UART transmitter (transmit / tx_byte / is_transmitting).
//
// Messages (highest priority first):
//   OVER  : "GAME OVER" (+ CR LF when NEWLINE = 1)
//   SCORE : "S:" + four BCD digits as 0x30 + digit (+ CR LF when NEWLINE = 1)
//   ECHO  : the single echoed character
//
// Each message type has one pending flag and one payload register, so a newer
// event of the same type replaces an older one that has not started yet.
// A message in progress is never preempted.
//
// Parameters:
//   NEWLINE      1 = score and game-over messages end with CR LF
// Ports:
//   clk          system clock
//   reset_n      synchronous, active-low reset
//   echo_valid   pulse: echo echo_char
//   echo_char    character to echo, sampled with echo_valid
//   score_valid  pulse: report score_bcd
//   score_bcd    four BCD digits, [15:12] most significant
//   over_valid   pulse: report game over
//   tx_busy      UART is_transmitting
//   transmit     UART start strobe, one cycle per byte
//   tx_byte      byte presented to the UART, 0x00 while idle
//   busy         a message is in progress or an event is pending
//   msg_done     one-cycle pulse after the last byte of a message is accepted
//   dropped      saturating count of echo events overwritten before being sent
// -----------------------------------------------------------------------------
module uart_reporter #(
  parameter bit NEWLINE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        echo_valid,
  input  logic [7:0]  echo_char,
  input  logic        score_valid,
  input  logic [15:0] score_bcd,
  input  logic        over_valid,
  input  logic        tx_busy,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        msg_done,
  output logic [7:0]  dropped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] T_ECHO  = 2'd0;
  localparam logic [1:0] T_SCORE = 2'd1;
  localparam logic [1:0] T_OVER  = 2'd2;

  // Index of the last byte of each message.
  localparam logic [3:0] ECHO_LAST  = 4'd0;
  localparam logic [3:0] SCORE_LAST = NEWLINE ? 4'd7  : 4'd5;
  localparam logic [3:0] OVER_LAST  = NEWLINE ? 4'd10 : 4'd8;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  last_idx;
  logic [1:0]  msg_type;
  logic [15:0] snap;

  logic        echo_pend;
  logic        score_pend;
  logic        over_pend;
  logic [7:0]  echo_data;
  logic [15:0] score_data;

  logic        any_pend;
  logic        clr_over;
  logic        clr_score;
  logic        clr_echo;
  logic [3:0]  digit;

  // ---------------------------------------------------------------------------
  // Message selection in IDLE: OVER > SCORE > ECHO.
  // ---------------------------------------------------------------------------
  assign any_pend  = over_pend | score_pend | echo_pend;
  assign clr_over  = (state == S_IDLE) & over_pend;
  assign clr_score = (state == S_IDLE) & ~over_pend & score_pend;
  assign clr_echo  = (state == S_IDLE) & ~over_pend & ~score_pend & echo_pend;

  // ---------------------------------------------------------------------------
  // Pending flags and payloads. A new pulse wins over the clear issued by the
  // selection in the same cycle: the snapshot already took the old payload, so
  // the flag stays set for the new one.
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: payload registers are reset too; they are plain flops, not a
      // memory array, so the cost is negligible and the reset state is clean.
      echo_pend  <= 1'b0;
      score_pend <= 1'b0;
      over_pend  <= 1'b0;
      echo_data  <= 8'h00;
      score_data <= 16'h0000;
      dropped    <= 8'h00;
    end else begin
      if (over_valid) begin
        over_pend <= 1'b1;
      end else if (clr_over) begin
        over_pend <= 1'b0;
      end

      if (score_valid) begin
        score_pend <= 1'b1;
        score_data <= score_bcd;
      end else if (clr_score) begin
        score_pend <= 1'b0;
      end

      if (echo_valid) begin
        echo_pend <= 1'b1;
        echo_data <= echo_char;
        // An echo taken into the snapshot this cycle is not lost.
        if (echo_pend && !clr_echo && dropped != 8'hFF) begin
          dropped <= dropped + 8'd1;
        end
      end else if (clr_echo) begin
        echo_pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= 4'd0;
      last_idx <= 4'd0;
      msg_type <= T_ECHO;
      snap     <= 16'h0000;
      msg_done <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            state <= S_START;
            idx   <= 4'd0;
            if (over_pend) begin
              msg_type <= T_OVER;
              last_idx <= OVER_LAST;
              snap     <= 16'h0000;
            end else if (score_pend) begin
              msg_type <= T_SCORE;
              last_idx <= SCORE_LAST;
              snap     <= score_data;
            end else begin
              msg_type <= T_ECHO;
              last_idx <= ECHO_LAST;
              snap     <= {8'h00, echo_data};
            end
          end
        end
        S_START: begin
          if (!tx_busy) state <= S_ACK;
        end
        S_ACK: begin
          // The UART raising busy is the acceptance of the current byte.
          if (tx_busy) begin
            if (idx == last_idx) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_START;
            end
          end
        end
        S_DONE: begin
          if (!tx_busy) begin
            msg_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign transmit = (state == S_START) & ~tx_busy;
  assign busy     = (state != S_IDLE) | any_pend;

  // ---------------------------------------------------------------------------
  // Byte mux: message type and index select the character.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (idx)
      4'd2:    digit = snap[15:12];
      4'd3:    digit = snap[11:8];
      4'd4:    digit = snap[7:4];
      default: digit = snap[3:0];
    endcase
  end

  // NOTE: tx_byte gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    tx_byte = 8'h00;
    if (state != S_IDLE) begin
      case (msg_type)
        T_ECHO: tx_byte = snap[7:0];
        T_SCORE: begin
          case (idx)
            4'd0:    tx_byte = 8'h53;                    // 'S'
            4'd1:    tx_byte = 8'h3A;                    // ':'
            4'd2, 4'd3, 4'd4, 4'd5:
                     tx_byte = 8'h30 + {4'h0, digit};    // no range check
            4'd6:    tx_byte = 8'h0D;
            4'd7:    tx_byte = 8'h0A;
            default: tx_byte = 8'h00;
          endcase
        end
        T_OVER: begin
          case (idx)
            4'd0:    tx_byte = 8'h47;                    // 'G'
            4'd1:    tx_byte = 8'h41;                    // 'A'
            4'd2:    tx_byte = 8'h4D;                    // 'M'
            4'd3:    tx_byte = 8'h45;                    // 'E'
            4'd4:    tx_byte = 8'h20;                    // ' '
            4'd5:    tx_byte = 8'h4F;                    // 'O'
            4'd6:    tx_byte = 8'h56;                    // 'V'
            4'd7:    tx_byte = 8'h45;                    // 'E'
            4'd8:    tx_byte = 8'h52;                    // 'R'
            4'd9:    tx_byte = 8'h0D;
            4'd10:   tx_byte = 8'h0A;
            default: tx_byte = 8'h00;
          endcase
        end
        default: tx_byte = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reporter.sv
// -----------------------------------------------------------------------------
// tb_uart_reporter
//
// Bench for uart_reporter. dut (NEWLINE = 1) is checked byte by byte against a
// message-level model of pending events; dut_nl0 (NEWLINE = 0) is checked
// against a literal byte list. Each DUT has a UART model that holds tx_busy
// high for 10 cycles after every accepted strobe.
// -----------------------------------------------------------------------------
module tb_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n     = 1'b0;
  logic        echo_valid  = 1'b0;
  logic [7:0]  echo_char   = 8'h00;
  logic        score_valid = 1'b0;
  logic [15:0] score_bcd   = 16'h0000;
  logic        over_valid  = 1'b0;
  logic        tx_busy;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        msg_done;
  logic [7:0]  dropped;
  logic        force_busy  = 1'b0;

  logic        score_valid2 = 1'b0;
  logic [15:0] score_bcd2   = 16'h0000;
  logic        echo_valid2  = 1'b0;
  logic [7:0]  echo_char2   = 8'h00;
  logic        over_valid2  = 1'b0;
  logic        tx_busy2;
  logic        transmit2;
  logic [7:0]  tx_byte2;
  logic        busy2;
  logic        msg_done2;
  logic [7:0]  dropped2;

  uart_reporter #(.NEWLINE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .echo_valid(echo_valid), .echo_char(echo_char),
    .score_valid(score_valid), .score_bcd(score_bcd),
    .over_valid(over_valid), .tx_busy(tx_busy),
    .transmit(transmit), .tx_byte(tx_byte), .busy(busy),
    .msg_done(msg_done), .dropped(dropped)
  );

  uart_reporter #(.NEWLINE(1'b0)) dut_nl0 (
    .clk(clk), .reset_n(reset_n),
    .echo_valid(echo_valid2), .echo_char(echo_char2),
    .score_valid(score_valid2), .score_bcd(score_bcd2),
    .over_valid(over_valid2), .tx_busy(tx_busy2),
    .transmit(transmit2), .tx_byte(tx_byte2), .busy(busy2),
    .msg_done(msg_done2), .dropped(dropped2)
  );

  // UART models: busy for 10 cycles after each strobe; not reset by reset_n.
  int u1_cnt = 0;
  int u2_cnt = 0;
  always @(posedge clk) begin
    if (u1_cnt != 0)   u1_cnt <= u1_cnt - 1;
    else if (transmit) u1_cnt <= 10;
    if (u2_cnt != 0)    u2_cnt <= u2_cnt - 1;
    else if (transmit2) u2_cnt <= 10;
  end
  assign tx_busy  = (u1_cnt != 0) || force_busy;
  assign tx_busy2 = (u2_cnt != 0);

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: pending events per type, expected byte stream of the message that
  // is on the wire. The next message is chosen when its first byte appears.
  // ---------------------------------------------------------------------------
  bit          m_over = 0, m_score = 0, m_echo = 0;
  logic [15:0] m_score_val = 16'h0;
  logic [7:0]  m_echo_val  = 8'h0;
  int          m_dropped   = 0;
  logic [7:0]  exp_q[$];

  task automatic load_next();
    string s;
    exp_q.delete();
    if (m_over) begin
      s = "GAME OVER";
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_over = 0;
    end else if (m_score) begin
      exp_q.push_back(8'h53);
      exp_q.push_back(8'h3A);
      for (int d = 3; d >= 0; d--) exp_q.push_back(8'h30 + {4'h0, m_score_val[d*4 +: 4]});
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_score = 0;
    end else if (m_echo) begin
      exp_q.push_back(m_echo_val);
      m_echo = 0;
    end
  endtask

  // Compare process for dut.
  int         strobes  = 0;
  int         done_cnt = 0;
  logic [7:0] byte_log[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (transmit) begin
        strobes++;
        byte_log.push_back(tx_byte);
        check("strobe_while_busy", {31'b0, tx_busy}, 32'd0);
        if (exp_q.size() == 0) load_next();
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe at %0t", tx_byte, $time);
        end else begin
          check("tx_byte", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
        end
      end
      if (msg_done) begin
        done_cnt++;
        check("msg_done_bytes_left", exp_q.size(), 32'd0);
      end
      if (!busy) begin
        check("idle_tx_byte", {24'b0, tx_byte}, 32'd0);
      end
    end
  end

  // Collector for dut_nl0.
  int         done2_cnt = 0;
  logic [7:0] log2[$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (transmit2) log2.push_back(tx_byte2);
      if (msg_done2) done2_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_echo(input logic [7:0] c);
    if (m_echo && m_dropped < 255) m_dropped++;
    m_echo = 1;
    m_echo_val = c;
    echo_char  = c;
    echo_valid = 1'b1;
    step();
    echo_valid = 1'b0;
  endtask

  task automatic ev_score(input logic [15:0] v);
    m_score = 1;
    m_score_val = v;
    score_bcd   = v;
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
  endtask

  task automatic ev_over();
    m_over = 1;
    over_valid = 1'b1;
    step();
    over_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      step();
      n++;
    end
    if (done_cnt < target) check(name, done_cnt, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_transmit"}, {31'b0, transmit}, 32'd0);
    check({tag, "_tx_byte"},  {24'b0, tx_byte},  32'd0);
    check({tag, "_busy"},     {31'b0, busy},     32'd0);
    check({tag, "_msg_done"}, {31'b0, msg_done}, 32'd0);
    check({tag, "_dropped"},  {24'b0, dropped},  32'd0);
  endtask

  logic [7:0] score_exp[8];
  logic [7:0] nl0_exp[6];
  int         s0;
  int         d0;
  int         viol;
  int         n;

  initial begin
    score_exp = '{8'h53, 8'h3A, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    nl0_exp   = '{8'h53, 8'h3A, 8'h39, 8'h38, 8'h37, 8'h30};

    // Reset.
    reset_n = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    reset_n = 1'b1;
    step();

    // Score 0x0123 with CR LF, including first-strobe latency.
    s0 = strobes;
    byte_log.delete();
    ev_score(16'h0123);
    check("score_busy_after_pulse", {31'b0, busy}, 32'd1);
    check("score_no_strobe_yet", {31'b0, transmit}, 32'd0);
    step();
    check("score_first_strobe", {31'b0, transmit}, 32'd1);
    check("score_first_byte", {24'b0, tx_byte}, 32'h53);
    wait_done(1, "timeout_score");
    check("score_strobes", strobes - s0, 32'd8);
    for (int i = 0; i < 8; i++) check("score_literal", {24'b0, byte_log[i]}, {24'b0, score_exp[i]});
    check("score_msg_done_count", done_cnt, 32'd1);
    check("score_busy_after", {31'b0, busy}, 32'd0);

    // Priority: OVER and ECHO 'a' in the same cycle.
    s0 = strobes;
    byte_log.delete();
    m_over = 1;
    if (m_echo && m_dropped < 255) m_dropped++;
    m_echo = 1;
    m_echo_val = 8'h61;
    over_valid = 1'b1;
    echo_valid = 1'b1;
    echo_char  = 8'h61;
    step();
    over_valid = 1'b0;
    echo_valid = 1'b0;
    wait_done(3, "timeout_priority");
    check("prio_strobes", strobes - s0, 32'd12);
    check("prio_first_byte", {24'b0, byte_log[0]}, 32'h47);
    check("prio_crlf", {16'b0, byte_log[9], byte_log[10]}, 32'h0D0A);
    check("prio_echo_last", {24'b0, byte_log[11]}, 32'h61);
    check("prio_dropped", {24'b0, dropped}, 32'd0);

    // Echo overwrite during a score message.
    s0 = strobes;
    byte_log.delete();
    ev_score(16'h4567);
    repeat (30) step();
    ev_echo(8'h61);
    repeat (5) step();
    ev_echo(8'h64);
    wait_done(5, "timeout_overwrite");
    check("ovw_strobes", strobes - s0, 32'd9);
    check("ovw_last_byte", {24'b0, byte_log[8]}, 32'h64);
    check("ovw_dropped", {24'b0, dropped}, 32'd1);
    check("ovw_dropped_model", {24'b0, dropped}, m_dropped);

    // Back-pressure: tx_busy held high for 100 cycles with an echo pending.
    s0 = strobes;
    force_busy = 1'b1;
    ev_echo(8'h7A);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (transmit) viol++;
    end
    check("bp_no_strobe", viol, 32'd0);
    check("bp_no_strobe_count", strobes - s0, 32'd0);
    force_busy = 1'b0;
    #1;
    check("bp_strobe_on_release", {31'b0, transmit}, 32'd1);
    check("bp_byte", {24'b0, tx_byte}, 32'h7A);
    wait_done(6, "timeout_backpressure");

    // Saturation: 301 echoes while a game-over message is held off.
    s0 = strobes;
    byte_log.delete();
    ev_over();
    n = 0;
    while (strobes == s0 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    force_busy = 1'b1;
    for (int i = 0; i < 301; i++) ev_echo((i == 300) ? 8'h6B : 8'h30 + 8'(i % 10));
    force_busy = 1'b0;
    wait_done(8, "timeout_saturate");
    check("sat_dropped", {24'b0, dropped}, 32'd255);
    check("sat_dropped_model", {24'b0, dropped}, m_dropped);
    check("sat_strobes", strobes - s0, 32'd12);
    check("sat_last_byte", {24'b0, byte_log[11]}, 32'h6B);

    // Reset at byte 3 of OVER with a score pending.
    s0 = strobes;
    d0 = done_cnt;
    ev_over();
    ev_score(16'h1111);
    n = 0;
    while (strobes - s0 < 3 && n < 200) begin
      step();
      n++;
    end
    check("rst_reached_byte3", strobes - s0, 32'd3);
    reset_n = 1'b0;
    m_over = 0; m_score = 0; m_echo = 0; m_dropped = 0;
    exp_q.delete();
    step();
    check_reset_values("midrst");
    reset_n = 1'b1;
    s0 = strobes;
    repeat (200) step();
    check("rst_no_strobes", strobes - s0, 32'd0);
    check("rst_no_msg_done", done_cnt, d0);
    byte_log.delete();
    ev_echo(8'h78);
    wait_done(d0 + 1, "timeout_after_reset");
    check("rst_echo_strobes", strobes - s0, 32'd1);
    check("rst_echo_byte", {24'b0, byte_log[0]}, 32'h78);

    // NEWLINE = 0: score 0x9870.
    score_bcd2   = 16'h9870;
    score_valid2 = 1'b1;
    step();
    score_valid2 = 1'b0;
    n = 0;
    while (done2_cnt < 1 && n < 1000) begin
      step();
      n++;
    end
    check("nl0_msg_done", done2_cnt, 32'd1);
    check("nl0_strobes", log2.size(), 32'd6);
    for (int i = 0; i < 6; i++) check("nl0_byte", {24'b0, log2[i]}, {24'b0, nl0_exp[i]});
    check("nl0_busy_after", {31'b0, busy2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
